// File: rtl/pos_to_quadrant.sv
// Maps a 10-bit pixel coordinate pair to the grid cell holding it, one register stage.
// Each axis is an independent constant divider: bit slice for power-of-two cells, compare chain otherwise.

module pos_to_quadrant_axis #(
  parameter int unsigned CELL = 64,
  parameter int unsigned GRID = 10
) (
  input  logic [9:0] pos,
  output logic [3:0] idx
);
  localparam int unsigned LIMIT  = CELL * GRID;
  localparam bit          IS_POW2 = ((CELL & (CELL - 1)) == 0);
  localparam int unsigned SH     = $clog2(CELL);

  logic [31:0] pos_w;
  logic [3:0]  raw;
  logic        oor;

  // Thresholds and range check are evaluated at 32 bits so no product can overflow.
  assign pos_w = {22'd0, pos};
  assign oor   = (pos_w >= LIMIT);

  if (IS_POW2) begin : g_slice
    assign raw = 4'(pos >> SH);
  end else begin : g_chain
    always_comb begin
      raw = 4'd0;
      for (int unsigned k = 1; k < GRID; k++) begin
        if (pos_w >= k * CELL) raw = raw + 4'd1;
      end
    end
  end

  // Truncated index only meaningful in range; out-of-range forces the F marker.
  assign idx = oor ? 4'hF : raw;
endmodule

module pos_to_quadrant #(
  parameter int unsigned CELL_W    = 64,
  parameter int unsigned CELL_H    = 48,
  parameter int unsigned GRID_COLS = 10,
  parameter int unsigned GRID_ROWS = 10
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic [3:0] cell_x,
  output logic [3:0] cell_y,
  output logic       in_grid
);
  logic [3:0] cell_x_d, cell_y_d, cell_x_q, cell_y_q;
  logic       in_grid_d, in_grid_q;

  pos_to_quadrant_axis #(.CELL(CELL_W), .GRID(GRID_COLS)) u_ax_x (
    .pos (pos_x),
    .idx (cell_x_d)
  );

  pos_to_quadrant_axis #(.CELL(CELL_H), .GRID(GRID_ROWS)) u_ax_y (
    .pos (pos_y),
    .idx (cell_y_d)
  );

  assign in_grid_d = (cell_x_d != 4'hF) && (cell_y_d != 4'hF);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cell_x_q  <= 4'd0;
      cell_y_q  <= 4'd0;
      in_grid_q <= 1'b0;
    end else begin
      cell_x_q  <= cell_x_d;
      cell_y_q  <= cell_y_d;
      in_grid_q <= in_grid_d;
    end
  end

  assign cell_x  = cell_x_q;
  assign cell_y  = cell_y_q;
  assign in_grid = in_grid_q;
endmodule

// File: tb/tb_pos_to_quadrant.sv
// Scoreboard bench for pos_to_quadrant: driver queues expected cells, monitor checks one cycle later.

module tb_pos_to_quadrant;
  logic       clk_in = 1'b0;
  logic       rst_n;
  logic [9:0] pos_x, pos_y;
  logic [3:0] cell_x, cell_y;
  logic       in_grid;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] cx;
    logic [3:0] cy;
    logic       ig;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  pos_to_quadrant dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .cell_x  (cell_x),
    .cell_y  (cell_y),
    .in_grid (in_grid)
  );

  always #20 clk_in = ~clk_in;

  function automatic exp_t ref_model(input int x, input int y);
    exp_t e;
    e.x  = x[9:0];
    e.y  = y[9:0];
    e.cx = (x >= 640) ? 4'hF : 4'(x / 64);
    e.cy = (y >= 480) ? 4'hF : 4'(y / 48);
    e.ig = (e.cx != 4'hF) && (e.cy != 4'hF);
    return e;
  endfunction

  task automatic chk_zero(input string name);
    checks++;
    if (cell_x !== 4'd0 || cell_y !== 4'd0 || in_grid !== 1'b0) begin
      failures++;
      $display("FAIL %s got (%h,%h,%b) want (0,0,0)", name, cell_x, cell_y, in_grid);
    end
  endtask

  // Directed vector with hand-computed expectation.
  task automatic step_exp(input int x, input int y, input logic [3:0] cx, input logic [3:0] cy,
                          input logic ig);
    exp_t e;
    @(negedge clk_in);
    pos_x = x[9:0];
    pos_y = y[9:0];
    e.x = x[9:0]; e.y = y[9:0]; e.cx = cx; e.cy = cy; e.ig = ig;
    q.push_back(e);
  endtask

  task automatic step_ref(input int x, input int y);
    @(negedge clk_in);
    pos_x = x[9:0];
    pos_y = y[9:0];
    q.push_back(ref_model(x, y));
  endtask

  // Monitor: every edge produces a result, checked 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (cell_x !== e.cx || cell_y !== e.cy || in_grid !== e.ig) begin
          failures++;
          $display("FAIL cell pos(%0d,%0d) got (%h,%h,%b) want (%h,%h,%b)",
                   e.x, e.y, cell_x, cell_y, in_grid, e.cx, e.cy, e.ig);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout queue=%0d", q.size());
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e0;
    rst_n = 1'b0;
    pos_x = 10'd300;
    pos_y = 10'd200;
    #5 chk_zero("reset_async");
    #5 rst_n = 1'b1;
    e0.x = 10'd300; e0.y = 10'd200; e0.cx = 4'd4; e0.cy = 4'd4; e0.ig = 1'b1;
    q.push_back(e0);

    // Boundaries and corners
    step_exp(63, 47, 4'd0, 4'd0, 1'b1);
    step_exp(64, 48, 4'd1, 4'd1, 1'b1);
    step_exp(127, 95, 4'd1, 4'd1, 1'b1);
    step_exp(128, 96, 4'd2, 4'd2, 1'b1);
    step_exp(0, 0, 4'd0, 4'd0, 1'b1);
    step_exp(639, 479, 4'd9, 4'd9, 1'b1);
    step_exp(575, 431, 4'd8, 4'd8, 1'b1);
    step_exp(576, 432, 4'd9, 4'd9, 1'b1);
    step_exp(383, 335, 4'd5, 4'd6, 1'b1);
    step_exp(384, 336, 4'd6, 4'd7, 1'b1);
    // Out of range, axes independent
    step_exp(640, 100, 4'hF, 4'd2, 1'b0);
    step_exp(100, 480, 4'd1, 4'hF, 1'b0);
    step_exp(1023, 1023, 4'hF, 4'hF, 1'b0);
    step_exp(639, 480, 4'd9, 4'hF, 1'b0);

    // Streaming sweep with a reset pulse between edges in the middle
    for (int x = 0; x < 800; x++) begin
      if (x == 400) begin
        @(negedge clk_in);
        pos_x = 10'd400;
        pos_y = 10'd250;
        #5 rst_n = 1'b0;
        #1 chk_zero("reset_midstream");
        @(posedge clk_in);
        #2 chk_zero("reset_hold");
        @(negedge clk_in);
        rst_n = 1'b1;
        q.push_back(ref_model(400, 250));
      end else begin
        step_ref(x, 250);
      end
    end

    @(negedge clk_in);
    @(negedge clk_in);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
